demux_tdm_rx: RTL and testbench

- Receive end of the team's time-division multiplexed link. A mux-based transmitter serializes N_CH channel samples onto one line, one slot per valid cycle, and marks slot 0 with frame_sync.
- This block de-interleaves the slots back into parallel per-channel registers. It presents each complete frame with a one-cycle strobe and flags framing errors.
- It sits directly downstream of the shared serial line and feeds the channel consumers.

---
 rtl/demux_tdm_rx.sv | 131 +++++++++++++
 tb/tb_demux_tdm_rx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/demux_tdm_rx.sv
// rtl/demux_tdm_rx.sv - TDM receiver: de-interleaves framed serial slots into parallel channel registers
//
// Ports:
//   clk         rising-edge system clock
//   rst_n       asynchronous active-low reset
//   din         slot data from the serial line (W bits)
//   din_valid   din holds a valid slot this cycle
//   frame_sync  qualified by din_valid; marks the slot as slot 0
//   dout        last complete frame; slot k at dout[k*W +: W]
//   dout_valid  one-cycle pulse when dout is updated
//   slot_idx    index of the next slot to be captured
//   busy        a frame is partially received
//   frame_err   one-cycle pulse on orphan slot, premature sync or inter-slot timeout
//   frame_cnt   completed frame count, wraps at 255
module demux_tdm_rx #(
    parameter int N_CH    = 4,
    parameter int W       = 1,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [W-1:0]             din,
    input  logic                     din_valid,
    input  logic                     frame_sync,
    output logic [N_CH*W-1:0]        dout,
    output logic                     dout_valid,
    output logic [$clog2(N_CH)-1:0]  slot_idx,
    output logic                     busy,
    output logic                     frame_err,
    output logic [7:0]               frame_cnt
);

    localparam int IW = $clog2(N_CH);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] LAST_SLOT = IW'(N_CH - 1);
    localparam logic [CW-1:0] TO_VAL    = CW'(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t              state;
    logic [N_CH*W-1:0]   shadow;
    logic [CW-1:0]       idle_cnt;
    logic [N_CH*W-1:0]   frame_next;

    // Completed frame: everything captured so far plus the slot arriving now.
    always_comb begin
        frame_next = shadow;
        frame_next[(N_CH-1)*W +: W] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shadow     <= '0;
            idle_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            slot_idx   <= '0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        if (frame_sync) begin
                            shadow        <= '0;
                            shadow[W-1:0] <= din;
                            slot_idx      <= IW'(1);
                            idle_cnt      <= '0;
                            busy          <= 1'b1;
                            state         <= RECV;
                        end else begin
                            // Slot with no frame to belong to: drop it.
                            frame_err <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (din_valid) begin
                        idle_cnt <= '0;
                        if (frame_sync) begin
                            // Premature sync restarts the frame on this slot.
                            frame_err     <= 1'b1;
                            shadow        <= '0;
                            shadow[W-1:0] <= din;
                            slot_idx      <= IW'(1);
                        end else begin
                            for (int k = 0; k < N_CH; k++) begin
                                if (slot_idx == IW'(k)) begin
                                    shadow[k*W +: W] <= din;
                                end
                            end
                            if (slot_idx == LAST_SLOT) begin
                                dout       <= frame_next;
                                dout_valid <= 1'b1;
                                frame_cnt  <= frame_cnt + 8'd1;
                                slot_idx   <= '0;
                                busy       <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                slot_idx <= slot_idx + IW'(1);
                            end
                        end
                    end else if (TIMEOUT != 0) begin
                        if (idle_cnt + CW'(1) == TO_VAL) begin
                            frame_err <= 1'b1;
                            shadow    <= '0;
                            idle_cnt  <= '0;
                            slot_idx  <= '0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_tdm_rx.sv
// tb/tb_demux_tdm_rx.sv - directed self-checking bench for demux_tdm_rx
module tb_demux_tdm_rx;

    logic       clk;
    logic       rst_n;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [3:0] dout;
    logic       dout_valid;
    logic [1:0] slot_idx;
    logic       busy;
    logic       frame_err;
    logic [7:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    demux_tdm_rx #(.N_CH(4), .W(1), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot_idx   (slot_idx),
        .busy       (busy),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic dv, input logic fe, input logic bz,
                           input logic [1:0] idx, input logic [3:0] d, input logic [7:0] cnt);
        chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(dv));
        chk({tag, ".frame_err"},  32'(frame_err),  32'(fe));
        chk({tag, ".busy"},       32'(busy),       32'(bz));
        chk({tag, ".slot_idx"},   32'(slot_idx),   32'(idx));
        chk({tag, ".dout"},       32'(dout),       32'(d));
        chk({tag, ".frame_cnt"},  32'(frame_cnt),  32'(cnt));
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic step(input logic d, input logic v, input logic s);
        din        = d;
        din_valid  = v;
        frame_sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
        #3;

        // Reset state
        do_reset();
        chk_all("rst", 0, 0, 0, 2'd0, 4'h0, 8'd0);

        // Single frame 1,0,1,1
        step(1, 1, 1); chk_all("f1.s0", 0, 0, 1, 2'd1, 4'h0, 8'd0);
        step(0, 1, 0); chk_all("f1.s1", 0, 0, 1, 2'd2, 4'h0, 8'd0);
        step(1, 1, 0); chk_all("f1.s2", 0, 0, 1, 2'd3, 4'h0, 8'd0);
        step(1, 1, 0); chk_all("f1.s3", 1, 0, 0, 2'd0, 4'b1101, 8'd1);
        step(0, 0, 0); chk_all("f1.after", 0, 0, 0, 2'd0, 4'b1101, 8'd1);

        // Back-to-back frames 0,1,0,0 and 1,1,1,0
        do_reset();
        step(0, 1, 1); chk_all("bb.c1", 0, 0, 1, 2'd1, 4'h0, 8'd0);
        step(1, 1, 0); chk_all("bb.c2", 0, 0, 1, 2'd2, 4'h0, 8'd0);
        step(0, 1, 0); chk_all("bb.c3", 0, 0, 1, 2'd3, 4'h0, 8'd0);
        step(0, 1, 0); chk_all("bb.c4", 1, 0, 0, 2'd0, 4'b0010, 8'd1);
        step(1, 1, 1); chk_all("bb.c5", 0, 0, 1, 2'd1, 4'b0010, 8'd1);
        step(1, 1, 0); chk_all("bb.c6", 0, 0, 1, 2'd2, 4'b0010, 8'd1);
        step(1, 1, 0); chk_all("bb.c7", 0, 0, 1, 2'd3, 4'b0010, 8'd1);
        step(0, 1, 0); chk_all("bb.c8", 1, 0, 0, 2'd0, 4'b0111, 8'd2);

        // Premature sync: 1,1 then sync 0, then 0,1,1
        do_reset();
        step(1, 1, 1); chk_all("ps.s0", 0, 0, 1, 2'd1, 4'h0, 8'd0);
        step(1, 1, 0); chk_all("ps.s1", 0, 0, 1, 2'd2, 4'h0, 8'd0);
        step(0, 1, 1); chk_all("ps.resync", 0, 1, 1, 2'd1, 4'h0, 8'd0);
        step(0, 1, 0); chk_all("ps.n1", 0, 0, 1, 2'd2, 4'h0, 8'd0);
        step(1, 1, 0); chk_all("ps.n2", 0, 0, 1, 2'd3, 4'h0, 8'd0);
        step(1, 1, 0); chk_all("ps.n3", 1, 0, 0, 2'd0, 4'b1100, 8'd1);

        // Gapped frame 1,0,1,0 with 3 idle cycles between slots
        do_reset();
        step(1, 1, 1); chk_all("gap.s0", 0, 0, 1, 2'd1, 4'h0, 8'd0);
        for (int g = 0; g < 3; g++) begin
            step(0, 0, 0); chk_all("gap.i0", 0, 0, 1, 2'd1, 4'h0, 8'd0);
        end
        step(0, 1, 0); chk_all("gap.s1", 0, 0, 1, 2'd2, 4'h0, 8'd0);
        for (int g = 0; g < 3; g++) begin
            step(0, 0, 0); chk_all("gap.i1", 0, 0, 1, 2'd2, 4'h0, 8'd0);
        end
        step(1, 1, 0); chk_all("gap.s2", 0, 0, 1, 2'd3, 4'h0, 8'd0);
        for (int g = 0; g < 3; g++) begin
            step(0, 0, 0); chk_all("gap.i2", 0, 0, 1, 2'd3, 4'h0, 8'd0);
        end
        step(0, 1, 0); chk_all("gap.s3", 1, 0, 0, 2'd0, 4'b0101, 8'd1);

        // Timeout: slot 0 then 16 idle cycles
        step(0, 1, 1); chk_all("to.s0", 0, 0, 1, 2'd1, 4'b0101, 8'd1);
        for (int g = 0; g < 15; g++) begin
            step(0, 0, 0); chk_all("to.wait", 0, 0, 1, 2'd1, 4'b0101, 8'd1);
        end
        step(0, 0, 0); chk_all("to.expire", 0, 1, 0, 2'd0, 4'b0101, 8'd1);
        step(0, 0, 0); chk_all("to.after", 0, 0, 0, 2'd0, 4'b0101, 8'd1);

        // Orphan slot while idle
        step(1, 1, 0); chk_all("orph", 0, 1, 0, 2'd0, 4'b0101, 8'd1);
        step(0, 0, 0); chk_all("orph.after", 0, 0, 0, 2'd0, 4'b0101, 8'd1);

        // Asynchronous reset mid-frame, then full frame 1,1,1,1
        do_reset();
        step(1, 1, 1);
        step(1, 1, 0); chk_all("ar.pre", 0, 0, 1, 2'd2, 4'h0, 8'd0);
        step(1, 1, 1);
        step(0, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0); chk_all("ar.fill", 1, 0, 0, 2'd0, 4'b1101, 8'd1);
        step(1, 1, 1);
        step(1, 1, 0); chk_all("ar.mid", 0, 0, 1, 2'd2, 4'b1101, 8'd1);
        #2;
        din_valid = 1'b0; frame_sync = 1'b0; din = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all("ar.async", 0, 0, 0, 2'd0, 4'h0, 8'd0);
        #2;
        rst_n = 1'b1;
        step(1, 1, 1); chk_all("ar.s0", 0, 0, 1, 2'd1, 4'h0, 8'd0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0); chk_all("ar.s3", 1, 0, 0, 2'd0, 4'b1111, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
